day_10_parser: RTL
==================

DAY_10_PARSER -- requirements
Module: day_10_parser

Interface
REQ-001 SHALL have parameter MAX_BUTTONS, default 6, maximum buttons per machine.
REQ-002 SHALL have parameter MAX_JOLTAGES, default 6, maximum lights/joltage counters per machine.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, width of joltage, button and config words.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port in_valid  input  1  input byte valid.
REQ-007 SHALL have port in_data  input  8  ASCII input byte.
REQ-008 SHALL have port in_ready  output  1  byte accepted when in_valid&&in_ready.
REQ-009 SHALL have port out_valid  output  1  parsed machine record valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the record.
REQ-011 SHALL have port out_config  output  DATA_WIDTH  [31:16]=button count, [15:0]=light count.
REQ-012 SHALL have port out_lights  output  MAX_JOLTAGES  target light mask, bit i = light i lit.
REQ-013 SHALL have port out_buttons  output  MAX_BUTTONS*DATA_WIDTH  word k = button k mask, bit j = counter j wired.
REQ-014 SHALL have port out_joltages  output  MAX_JOLTAGES*DATA_WIDTH  word j = joltage target j.
REQ-015 SHALL have port machine_count  output  16  records emitted since reset.
REQ-016 SHALL have port parse_error  output  1  sticky flag, a line was dropped.

Function
REQ-017 SHALL parse lines of the form "[.##.] (3) (1,3) {3,5,4,7}" terminated by 0x0A; 0x20 and 0x0D are ignored everywhere.
REQ-018 SHALL implement states LINE_START, LIGHTS, SEEK, BUTTON, JOLT, EMIT, SKIP.
REQ-019 SHALL, in LINE_START: '[' -> LIGHTS; 0x0A -> LINE_START (blank line, no record); any other byte -> error.
REQ-020 SHALL, in LIGHTS: set bit n for '#' and clear it for '.', where n is the running light index from 0; ']' -> SEEK.
REQ-021 SHALL, in SEEK: '(' -> BUTTON; '{' -> JOLT; any other byte -> error.
REQ-022 SHALL, in BUTTON: accumulate decimal digits; ',' or ')' sets bit <value> in button word k; ')' increments k and returns to SEEK.
REQ-023 SHALL, in JOLT: accumulate decimal as acc = acc*10 + digit, modulo 2^DATA_WIDTH; ',' or '}' stores joltage j; '}' -> await 0x0A.
REQ-024 SHALL, on the 0x0A after '}', register the record and enter EMIT; out_valid SHALL rise the cycle after that byte is accepted.
REQ-025 SHALL clear all unused button and joltage words to 0 in each emitted record.
REQ-026 SHALL drive in_ready = !out_valid, giving a 1-record output buffer; outputs SHALL hold stable while out_valid && !out_ready.
REQ-027 SHALL, on out_valid && out_ready: clear out_valid, increment machine_count (wrapping at 2^16), and return to LINE_START.
REQ-028 SHALL treat each of the following as an error: light count > MAX_JOLTAGES; button count > MAX_BUTTONS; button index >= light count; joltage count != light count; any unexpected character.
REQ-029 SHALL, on error: set parse_error, discard the line, enter SKIP, and return to LINE_START after 0x0A; no record is emitted for that line.
REQ-030 SHALL clear per-line accumulators at each LINE_START entry.

Reset
REQ-031 SHALL, while rst is high: state=LINE_START, out_valid=0, in_ready=1, out_config/out_lights/out_buttons/out_joltages=0, machine_count=0, parse_error=0.
REQ-032 SHALL, on rst assertion mid-line or mid-EMIT, abandon the partial or pending record with no output.

Verification
REQ-033 SHALL be tested with "[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n" -> out_config=0x00060004, lights=0110b, buttons=8,A,4,C,5,3, joltages=3,5,4,7,0,0.
REQ-034 SHALL be tested with out_ready held low 10 cycles after the record -> in_ready=0 and outputs stable; on accept, machine_count=1.
REQ-035 SHALL be tested with "[#.] (0) (1) {123,40000}\n" -> out_lights=01b, joltages=123,40000, config=0x00020002.
REQ-036 SHALL be tested with a 7-button line followed by a valid line -> parse_error=1, one record emitted (the valid line only).
REQ-037 SHALL be tested with a blank line and "\r\n" endings -> no spurious record, normal parse.
REQ-038 SHALL be tested with rst pulsed mid-line, then a full line -> only the post-reset record is emitted, machine_count=1.

Source files
------------

// File: rtl/day_10_parser.sv
// Byte-stream parser for "[lights] (buttons)... {joltages}" machine description lines.
// Each well-formed line becomes one record held in a single-entry valid/ready output buffer.
module day_10_parser #(
  parameter int unsigned MAX_BUTTONS  = 6,
  parameter int unsigned MAX_JOLTAGES = 6,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic [7:0]                         in_data,
  output logic                               in_ready,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH-1:0]              out_config,
  output logic [MAX_JOLTAGES-1:0]            out_lights,
  output logic [MAX_BUTTONS*DATA_WIDTH-1:0]  out_buttons,
  output logic [MAX_JOLTAGES*DATA_WIDTH-1:0] out_joltages,
  output logic [15:0]                        machine_count,
  output logic                               parse_error
);
  localparam int unsigned LW = $clog2(MAX_JOLTAGES + 1);
  localparam int unsigned BW = $clog2(MAX_BUTTONS + 1);

  localparam logic [7:0] C_LF    = 8'h0A;
  localparam logic [7:0] C_CR    = 8'h0D;
  localparam logic [7:0] C_SP    = 8'h20;
  localparam logic [7:0] C_LBRK  = "[";
  localparam logic [7:0] C_RBRK  = "]";
  localparam logic [7:0] C_HASH  = "#";
  localparam logic [7:0] C_DOT   = ".";
  localparam logic [7:0] C_LPAR  = "(";
  localparam logic [7:0] C_RPAR  = ")";
  localparam logic [7:0] C_LBRC  = "{";
  localparam logic [7:0] C_RBRC  = "}";
  localparam logic [7:0] C_COMMA = ",";
  localparam logic [7:0] C_ZERO  = "0";
  localparam logic [7:0] C_NINE  = "9";

  typedef enum logic [2:0] {
    LINE_START, LIGHTS, SEEK, BUTTON, JOLT, EMIT, SKIP
  } state_t;

  state_t r_state, w_next_state;

  logic [LW-1:0]                          r_nlights, r_njolts;
  logic [BW-1:0]                          r_nbuttons;
  logic [DATA_WIDTH-1:0]                  r_acc;
  logic                                   r_have_digit, r_closed;
  logic [MAX_JOLTAGES-1:0]                r_lights;
  logic [MAX_BUTTONS-1:0][DATA_WIDTH-1:0] r_buttons;
  logic [MAX_JOLTAGES-1:0][DATA_WIDTH-1:0] r_jolts;

  logic                                    r_out_valid;
  logic [DATA_WIDTH-1:0]                   r_out_config;
  logic [MAX_JOLTAGES-1:0]                 r_out_lights;
  logic [MAX_BUTTONS-1:0][DATA_WIDTH-1:0]  r_out_buttons;
  logic [MAX_JOLTAGES-1:0][DATA_WIDTH-1:0] r_out_jolts;
  logic [15:0]                             r_count;
  logic                                    r_parse_error;

  logic                    w_accept, w_ws, w_is_digit, w_done;
  logic [DATA_WIDTH-1:0]   w_acc_next, w_btn_mask;
  logic [MAX_JOLTAGES-1:0] w_light_mask;
  logic w_err, w_light_wr, w_digit_wr, w_btn_bit, w_btn_close, w_jolt_wr, w_close, w_emit, w_clear;

  assign w_accept     = in_valid && !r_out_valid;
  assign w_ws         = (in_data == C_SP) || (in_data == C_CR);
  assign w_is_digit   = (in_data >= C_ZERO) && (in_data <= C_NINE);
  assign w_done       = r_out_valid && out_ready;
  assign w_acc_next   = (r_acc << 3) + (r_acc << 1) + DATA_WIDTH'(in_data - C_ZERO);
  assign w_btn_mask   = DATA_WIDTH'(1) << r_acc;
  assign w_light_mask = MAX_JOLTAGES'(1) << r_nlights;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= LINE_START;
    else     r_state <= w_next_state;
  end

  // Next state plus one-cycle datapath strobes for the accepted byte.
  always_comb begin
    w_next_state = r_state;
    w_err        = 1'b0;
    w_light_wr   = 1'b0;
    w_digit_wr   = 1'b0;
    w_btn_bit    = 1'b0;
    w_btn_close  = 1'b0;
    w_jolt_wr    = 1'b0;
    w_close      = 1'b0;
    w_emit       = 1'b0;
    if (r_state == EMIT) begin
      if (w_done) w_next_state = LINE_START;
    end else if (w_accept && !w_ws) begin
      case (r_state)
        LINE_START: begin
          if (in_data == C_LBRK)    w_next_state = LIGHTS;
          else if (in_data != C_LF) w_err = 1'b1;
        end
        LIGHTS: begin
          if ((in_data == C_HASH) || (in_data == C_DOT)) begin
            if (r_nlights == LW'(MAX_JOLTAGES)) w_err = 1'b1;
            else                                w_light_wr = 1'b1;
          end else if (in_data == C_RBRK) begin
            w_next_state = SEEK;
          end else begin
            w_err = 1'b1;
          end
        end
        SEEK: begin
          if (in_data == C_LPAR) begin
            if (r_nbuttons == BW'(MAX_BUTTONS)) w_err = 1'b1;
            else                                w_next_state = BUTTON;
          end else if (in_data == C_LBRC) begin
            w_next_state = JOLT;
          end else begin
            w_err = 1'b1;
          end
        end
        BUTTON: begin
          if (w_is_digit) begin
            w_digit_wr = 1'b1;
          end else if ((in_data == C_COMMA) || (in_data == C_RPAR)) begin
            if (!r_have_digit || (r_acc >= DATA_WIDTH'(r_nlights))) begin
              w_err = 1'b1;
            end else begin
              w_btn_bit = 1'b1;
              if (in_data == C_RPAR) begin
                w_btn_close  = 1'b1;
                w_next_state = SEEK;
              end
            end
          end else begin
            w_err = 1'b1;
          end
        end
        JOLT: begin
          if (r_closed) begin
            if (in_data == C_LF) begin
              w_emit       = 1'b1;
              w_next_state = EMIT;
            end else begin
              w_err = 1'b1;
            end
          end else if (w_is_digit) begin
            w_digit_wr = 1'b1;
          end else if ((in_data == C_COMMA) || (in_data == C_RBRC)) begin
            if (!r_have_digit || (r_njolts == LW'(MAX_JOLTAGES))) begin
              w_err = 1'b1;
            end else begin
              w_jolt_wr = 1'b1;
              if (in_data == C_RBRC) begin
                if ((r_njolts + LW'(1)) != r_nlights) w_err = 1'b1;
                else                                 w_close = 1'b1;
              end
            end
          end else begin
            w_err = 1'b1;
          end
        end
        SKIP: begin
          if (in_data == C_LF) w_next_state = LINE_START;
        end
        default: w_next_state = LINE_START;
      endcase
      // A newline that is itself the bad byte already ends the line.
      if (w_err) w_next_state = (in_data == C_LF) ? LINE_START : SKIP;
    end
    w_clear = (w_next_state == LINE_START);
  end

  // Per-line accumulators, wiped on every entry into LINE_START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nlights    <= '0;
      r_njolts     <= '0;
      r_nbuttons   <= '0;
      r_acc        <= '0;
      r_have_digit <= 1'b0;
      r_closed     <= 1'b0;
      r_lights     <= '0;
      r_buttons    <= '0;
      r_jolts      <= '0;
    end else if (w_clear) begin
      r_nlights    <= '0;
      r_njolts     <= '0;
      r_nbuttons   <= '0;
      r_acc        <= '0;
      r_have_digit <= 1'b0;
      r_closed     <= 1'b0;
      r_lights     <= '0;
      r_buttons    <= '0;
      r_jolts      <= '0;
    end else begin
      if (w_light_wr) begin
        r_lights  <= (in_data == C_HASH) ? (r_lights | w_light_mask) : (r_lights & ~w_light_mask);
        r_nlights <= r_nlights + LW'(1);
      end
      if (w_digit_wr) begin
        r_acc        <= w_acc_next;
        r_have_digit <= 1'b1;
      end
      if (w_btn_bit) begin
        r_buttons[r_nbuttons] <= r_buttons[r_nbuttons] | w_btn_mask;
        r_acc                 <= '0;
        r_have_digit          <= 1'b0;
      end
      if (w_btn_close) r_nbuttons <= r_nbuttons + BW'(1);
      if (w_jolt_wr) begin
        r_jolts[r_njolts] <= r_acc;
        r_njolts          <= r_njolts + LW'(1);
        r_acc             <= '0;
        r_have_digit      <= 1'b0;
      end
      if (w_close) r_closed <= 1'b1;
    end
  end

  // Single-entry output buffer, record counter and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_config  <= '0;
      r_out_lights  <= '0;
      r_out_buttons <= '0;
      r_out_jolts   <= '0;
      r_count       <= '0;
      r_parse_error <= 1'b0;
    end else begin
      if (w_emit) begin
        r_out_valid   <= 1'b1;
        r_out_config  <= DATA_WIDTH'({16'(r_nbuttons), 16'(r_nlights)});
        r_out_lights  <= r_lights;
        r_out_buttons <= r_buttons;
        r_out_jolts   <= r_jolts;
      end else if (w_done) begin
        r_out_valid <= 1'b0;
        r_count     <= r_count + 16'd1;
      end
      if (w_err) r_parse_error <= 1'b1;
    end
  end

  assign in_ready      = !r_out_valid;
  assign out_valid     = r_out_valid;
  assign out_config    = r_out_config;
  assign out_lights    = r_out_lights;
  assign out_buttons   = r_out_buttons;
  assign out_joltages  = r_out_jolts;
  assign machine_count = r_count;
  assign parse_error   = r_parse_error;

endmodule
